onehot_scan_decoder: RTL

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder. Successor to the fixed 3-to-8 combinational decoder.

---
 rtl/onehot_scan_decoder_if.sv | 17 +
 rtl/onehot_scan_decoder.sv | 92 +++++++++
 2 files changed

// File: rtl/onehot_scan_decoder_if.sv
// Bus bundle for onehot_scan_decoder: control inputs from the master and the registered channel drive back.
interface onehot_scan_decoder_if #(
    parameter int unsigned SEL_W = 3
);
    localparam int unsigned N = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel_in;
    logic [N-1:0]     mask;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] idx;
    logic             tick;

    modport master (output en, mode, sel_in, mask, input out, idx, tick);
    modport slave  (input en, mode, sel_in, mask, output out, idx, tick);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and prescaled scan modes.
// Define DEC_BLANK_GUARD_EN to insert one dead output cycle on every scan-mode channel change.
module onehot_scan_decoder #(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DIV        = 100000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    onehot_scan_decoder_if.slave bus
);
    localparam int unsigned   N          = 1 << SEL_W;
    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [N-1:0]  INACT      = {N{ACTIVE_LOW}};
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_t;

    mode_t            mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N-1:0]     out_q, out_d;
    logic             tick_q, tick_d;

    logic [SEL_W-1:0] scan_next;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic             presc_wrap;

    function automatic logic [N-1:0] drive(input logic active, input logic [SEL_W-1:0] k);
        drive = active ? (INACT ^ (N'(1) << k)) : INACT;
    endfunction

    // Offsets 1..N-1 from idx_q, wrapping modulo N, give "smallest above, else smallest overall".
    always_comb begin
        scan_next = idx_q;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k < N; k++) begin
            cand = idx_q + SEL_W'(k);
            if (!found && bus.mask[cand]) begin
                scan_next = cand;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        mode_d     = bus.mode ? MODE_SCAN : MODE_DIRECT;
        presc_d    = '0;
        tick_d     = 1'b0;
        idx_d      = bus.sel_in;
        out_d      = INACT;
        presc_wrap = (presc_q == PRESC_LAST);

        if (!bus.mode) begin
            out_d = drive(bus.en, bus.sel_in);
        end else if (mode_q == MODE_DIRECT) begin
            out_d = drive(bus.en && bus.mask[bus.sel_in], bus.sel_in);
        end else begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            tick_d  = presc_wrap;
            idx_d   = presc_wrap ? scan_next : idx_q;
            out_d   = drive(bus.en && bus.mask[idx_d], idx_d);
`ifdef DEC_BLANK_GUARD_EN
            if (idx_d != idx_q) begin
                out_d = INACT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_DIRECT;
            presc_q <= '0;
            idx_q   <= '0;
            out_q   <= INACT;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.tick = tick_q;
endmodule
